// File: rtl/dmem_responder.sv
// Data-memory responder for the core's EXE-stage load/store requests.
// Routes each request to word RAM or a three-register MMIO timer block,
// applies RV32I byte-lane store masking and load extraction, and returns
// the load result one cycle after the request together with a misalignment
// pulse. The timer raises a sticky interrupt when MTIME reaches MTIMECMP.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        Wmem,
    input  logic        Rmem,
    output logic [31:0] memOut,
    output logic        misaligned,
    output logic        timerIrq
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Pulls the addressed byte/halfword/word out of a read word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0]  fn,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic signed [7:0]  byte_v;
        logic signed [15:0] half_v;
        logic [31:0]        res;
        byte_v = word[8*lane +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (fn)
            F3_B:    res = {{24{byte_v[7]}}, byte_v};
            F3_H:    res = {{16{half_v[15]}}, half_v};
            F3_W:    res = word;
            F3_BU:   res = {24'd0, byte_v};
            F3_HU:   res = {16'd0, half_v};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Byte-lane write enables for a store; invalid store widths enable nothing.
    function automatic logic [3:0] store_lanes(input logic [2:0] fn,
                                               input logic [1:0] lane);
        logic [3:0] be;
        case (fn)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so each enabled lane sees its bytes.
    function automatic logic [31:0] store_data(input logic [2:0]  fn,
                                               input logic [31:0] d);
        logic [31:0] wd;
        case (fn)
            F3_B:    wd = {4{d[7:0]}};
            F3_H:    wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    logic [31:0]   ram [DEPTH];

    logic [AW-1:0] ram_idx_p0;
    logic [29:0]   mmio_off_p0;
    logic          in_ram_p0;
    logic          in_mmio_p0;
    logic          st_mis_p0;
    logic          ld_mis_p0;
    logic          mis_p0;
    logic          vld_p0;
    logic [3:0]    be_p0;
    logic [31:0]   wdata_p0;
    logic          ram_we_p0;
    logic          mmio_we_p0;
    logic          wr_mtime_p0;
    logic          wr_cmp_p0;
    logic          wr_ctrl_p0;
    logic [31:0]   mmio_word_p0;

    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic          tmr_en;
    logic          tmr_pend;
    logic          pend_set;

    logic          vld_p1;
    logic          mis_p1;
    logic [2:0]    f3_p1;
    logic [1:0]    lane_p1;
    logic          sel_ram_p1;
    logic          sel_mmio_p1;
    logic [31:0]   ram_rd_p1;
    logic [31:0]   mmio_rd_p1;
    logic [31:0]   word_p1;

    // Stage p0: decode region, alignment and byte lanes of the incoming request.
    always_comb begin
        ram_idx_p0  = addr[AW+1:2];
        mmio_off_p0 = addr[31:2] - MMIO_BASE[31:2];
        in_ram_p0   = addr < RAM_BYTES;
        in_mmio_p0  = mmio_off_p0 < 30'd3;

        st_mis_p0 = ((f3 == F3_H) && addr[0]) ||
                    ((f3 == F3_W) && (addr[1:0] != 2'b00));
        ld_mis_p0 = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
                    ((f3 == F3_W) && (addr[1:0] != 2'b00));

        // A combined store+load is treated purely as a store.
        mis_p0 = Wmem ? st_mis_p0 : (Rmem && ld_mis_p0);
        vld_p0 = Rmem && !Wmem && !ld_mis_p0;

        be_p0    = store_lanes(f3, addr[1:0]);
        wdata_p0 = store_data(f3, data);

        ram_we_p0  = Wmem && !Reset && in_ram_p0 && !st_mis_p0;
        // MMIO registers accept only aligned full-word stores.
        mmio_we_p0 = Wmem && !Reset && in_mmio_p0 && (f3 == F3_W) &&
                     (addr[1:0] == 2'b00);

        wr_mtime_p0 = mmio_we_p0 && (mmio_off_p0[1:0] == 2'd0);
        wr_cmp_p0   = mmio_we_p0 && (mmio_off_p0[1:0] == 2'd1);
        wr_ctrl_p0  = mmio_we_p0 && (mmio_off_p0[1:0] == 2'd2);

        case (mmio_off_p0[1:0])
            2'd0:    mmio_word_p0 = mtime;
            2'd1:    mmio_word_p0 = mtimecmp;
            2'd2:    mmio_word_p0 = {30'd0, tmr_pend, tmr_en};
            default: mmio_word_p0 = 32'd0;
        endcase

        // Compare uses the value MTIME holds this cycle, before any increment.
        pend_set = tmr_en && (mtime == mtimecmp);
    end

    // Timer block: free-running counter, compare register, enable and sticky pending.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mtime    <= 32'd0;
            mtimecmp <= 32'hFFFF_FFFF;
            tmr_en   <= 1'b0;
            tmr_pend <= 1'b0;
        end else begin
            if (wr_mtime_p0)
                mtime <= data;
            else if (tmr_en)
                mtime <= mtime + 32'd1;
            if (wr_cmp_p0)
                mtimecmp <= data;
            if (wr_ctrl_p0)
                tmr_en <= data[0];
            // A new match outranks a simultaneous write-1-to-clear.
            if (pend_set)
                tmr_pend <= 1'b1;
            else if (wr_ctrl_p0 && data[1])
                tmr_pend <= 1'b0;
        end
    end

    // RAM: byte-lane writes and a registered read of the requested word.
    always_ff @(posedge Clock) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we_p0 && be_p0[b])
                ram[ram_idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
        end
        ram_rd_p1 <= ram[ram_idx_p0];
    end

    // Stage p1 control: load-valid and misalignment flags, cleared by reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld_p1 <= 1'b0;
            mis_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            mis_p1 <= mis_p0;
        end
    end

    // Stage p1 data: access width, lane, region and MMIO read value.
    always_ff @(posedge Clock) begin
        f3_p1       <= f3;
        lane_p1     <= addr[1:0];
        sel_ram_p1  <= in_ram_p0;
        sel_mmio_p1 <= in_mmio_p0 && !in_ram_p0;
        mmio_rd_p1  <= mmio_word_p0;
    end

    // Stage p1 output: select the region word and extract the loaded lanes.
    always_comb begin
        if (sel_ram_p1)
            word_p1 = ram_rd_p1;
        else if (sel_mmio_p1)
            word_p1 = mmio_rd_p1;
        else
            word_p1 = 32'd0;
        memOut = vld_p1 ? load_extract(f3_p1, lane_p1, word_p1) : 32'd0;
    end

    assign misaligned = mis_p1;
    assign timerIrq   = tmr_pend;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lane stores/loads, misalignment,
// unmapped accesses, MMIO timer behaviour and mid-operation reset.
module tb_dmem_responder;

    localparam logic [31:0] MM = 32'hFFFF_0000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  f3    = 3'b000;
    logic [31:0] addr  = 32'd0;
    logic [31:0] data  = 32'd0;
    logic        Wmem  = 1'b0;
    logic        Rmem  = 1'b0;
    logic [31:0] memOut;
    logic        misaligned;
    logic        timerIrq;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH(1024), .MMIO_BASE(MM)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .f3         (f3),
        .addr       (addr),
        .data       (data),
        .Wmem       (Wmem),
        .Rmem       (Rmem),
        .memOut     (memOut),
        .misaligned (misaligned),
        .timerIrq   (timerIrq)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request cycle: drive on the falling edge, sample just after the rising edge.
    task automatic cyc(input logic rst, input logic w, input logic r,
                       input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
        @(negedge Clock);
        Reset = rst;
        Wmem  = w;
        Rmem  = r;
        f3    = fn;
        addr  = a;
        data  = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic st(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, fn, a, d);
    endtask

    task automatic ld(input logic [2:0] fn, input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b1, fn, a, 32'd0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check("rst_memOut", memOut, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_timerIrq", {31'd0, timerIrq}, 32'd0);

        ld(3'b010, MM);        check("rst_mtime", memOut, 32'd0);
        ld(3'b010, MM + 4);    check("rst_mtimecmp", memOut, 32'hFFFF_FFFF);
        ld(3'b010, MM + 8);    check("rst_ctrl", memOut, 32'd0);

        // Lane extraction from a known word
        st(3'b010, 32'h10, 32'hDEAD_BEEF);  check("sw_no_load", memOut, 32'd0);
        ld(3'b000, 32'h13);    check("lb_13", memOut, 32'hFFFF_FFDE);
        check("lb_not_mis", {31'd0, misaligned}, 32'd0);
        ld(3'b100, 32'h13);    check("lbu_13", memOut, 32'h0000_00DE);
        ld(3'b001, 32'h12);    check("lh_12", memOut, 32'hFFFF_DEAD);
        ld(3'b101, 32'h10);    check("lhu_10", memOut, 32'h0000_BEEF);
        ld(3'b000, 32'h10);    check("lb_10", memOut, 32'hFFFF_FFEF);
        ld(3'b001, 32'h10);    check("lh_10", memOut, 32'hFFFF_BEEF);
        ld(3'b011, 32'h10);    check("ld_f3_011", memOut, 32'd0);
        ld(3'b110, 32'h10);    check("ld_f3_110", memOut, 32'd0);
        check("ld_f3_110_mis", {31'd0, misaligned}, 32'd0);

        // Byte store followed immediately by a word load
        st(3'b000, 32'h11, 32'h0000_0055);
        ld(3'b010, 32'h10);    check("sb_write_first", memOut, 32'hDEAD_55EF);

        // Misaligned word load and halfword store
        ld(3'b010, 32'h12);
        check("lw_mis_flag", {31'd0, misaligned}, 32'd1);
        check("lw_mis_data", memOut, 32'd0);
        st(3'b001, 32'h13, 32'h0000_AAAA);
        check("sh_mis_flag", {31'd0, misaligned}, 32'd1);
        idle();                check("mis_pulse_end", {31'd0, misaligned}, 32'd0);
        ld(3'b010, 32'h10);    check("sh_mis_no_write", memOut, 32'hDEAD_55EF);

        // Simultaneous store and load
        cyc(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0000_1234);
        check("wr_rd_memOut", memOut, 32'd0);
        ld(3'b010, 32'h20);    check("wr_rd_stored", memOut, 32'h0000_1234);

        // Unmapped and dropped accesses
        st(3'b010, 32'h1010, 32'h1111_1111);
        ld(3'b010, 32'h10);    check("unmapped_st_drop", memOut, 32'hDEAD_55EF);
        ld(3'b010, 32'h1010);  check("unmapped_ld", memOut, 32'd0);
        ld(3'b010, MM + 12);   check("mmio_hole_ld", memOut, 32'd0);
        st(3'b000, MM + 4, 32'd0);
        ld(3'b010, MM + 4);    check("mmio_sb_drop", memOut, 32'hFFFF_FFFF);

        // Timer: compare at 5, then count from 0
        st(3'b010, MM + 4, 32'd5);
        st(3'b010, MM + 8, 32'd1);
        for (int i = 0; i < 6; i++) begin
            ld(3'b010, MM);
            check($sformatf("mtime_%0d", i), memOut, 32'(i));
            check($sformatf("irq_%0d", i), {31'd0, timerIrq}, (i == 5) ? 32'd1 : 32'd0);
        end
        st(3'b010, MM + 8, 32'd3);  check("w1c_irq", {31'd0, timerIrq}, 32'd0);
        ld(3'b010, MM + 8);         check("w1c_ctrl", memOut, 32'd1);
        st(3'b010, MM, 32'hFFFF_FFFF);
        ld(3'b010, MM);             check("mtime_max", memOut, 32'hFFFF_FFFF);
        ld(3'b010, MM);             check("mtime_wrap", memOut, 32'd0);

        // Match and W1C in the same cycle, then disable keeps pending
        st(3'b010, MM + 4, 32'd3);
        idle();
        st(3'b010, MM + 8, 32'd3);  check("set_beats_clr", {31'd0, timerIrq}, 32'd1);
        st(3'b010, MM + 8, 32'd0);  check("pend_after_disable", {31'd0, timerIrq}, 32'd1);
        ld(3'b010, MM + 8);         check("ctrl_pend_only", memOut, 32'd2);

        // Reset asserted during a load and during a store
        cyc(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0);
        check("rst_mid_memOut", memOut, 32'd0);
        check("rst_mid_irq", {31'd0, timerIrq}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0BAD_0BAD);
        ld(3'b010, MM);             check("rst_mid_mtime", memOut, 32'd0);
        ld(3'b010, MM + 4);         check("rst_mid_cmp", memOut, 32'hFFFF_FFFF);
        ld(3'b010, 32'h10);         check("rst_st_dropped", memOut, 32'hDEAD_55EF);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
